// File: rtl/expand_output_writer_if.sv
// expand_output_writer_if
//   Bundles the two expand result FIFO read ports and the layer-RAM write
//   port of expand_output_writer.
//   Signals:
//     fifo_exp_3x3_rd_data_i/_rd_en_o/_empty_i  expand-3x3 result FIFO read port
//     fifo_exp_1x1_rd_data_i/_rd_en_o/_empty_i  expand-1x1 result FIFO read port
//     out_valid_o/out_ready_i/out_addr_o/out_data_o  layer-RAM write handshake
//   Modports:
//     master : the writer (pops FIFOs, drives the write port)
//     slave  : the environment (FIFOs and layer-RAM)
interface expand_output_writer_if;
    logic [47:0] fifo_exp_3x3_rd_data_i;
    logic        fifo_exp_3x3_rd_en_o;
    logic        fifo_exp_3x3_empty_i;
    logic [47:0] fifo_exp_1x1_rd_data_i;
    logic        fifo_exp_1x1_rd_en_o;
    logic        fifo_exp_1x1_empty_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_addr_o;
    logic [63:0] out_data_o;

    modport master (
        input  fifo_exp_3x3_rd_data_i,
        output fifo_exp_3x3_rd_en_o,
        input  fifo_exp_3x3_empty_i,
        input  fifo_exp_1x1_rd_data_i,
        output fifo_exp_1x1_rd_en_o,
        input  fifo_exp_1x1_empty_i,
        output out_valid_o,
        input  out_ready_i,
        output out_addr_o,
        output out_data_o
    );

    modport slave (
        output fifo_exp_3x3_rd_data_i,
        input  fifo_exp_3x3_rd_en_o,
        output fifo_exp_3x3_empty_i,
        output fifo_exp_1x1_rd_data_i,
        input  fifo_exp_1x1_rd_en_o,
        output fifo_exp_1x1_empty_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_addr_o,
        input  out_data_o
    );
endinterface

// File: rtl/expand_output_writer.sv
// expand_output_writer
//   Pops the expand-3x3 and expand-1x1 result FIFOs in lock-step, applies
//   ReLU, a right shift and 8-bit saturation to each of the four 12-bit
//   signed lanes per word, and writes the packed 64-bit fire-module word to
//   the layer RAM with an incrementing address under valid/ready.
//   Ports:
//     clk_i            system clock, rising edge
//     rst_i            asynchronous active-high reset
//     start_i          one-cycle pulse: load config, clear pipeline, run
//     out_ch_groups_i  4-channel groups per pixel (sampled on start_i)
//     pixel_count_i    output pixels in layer (sampled on start_i)
//     shift_i          requantize right shift 0-7 (sampled on start_i)
//     base_addr_i      first write address (sampled on start_i)
//     bus              FIFO read ports and layer-RAM write port (master)
//     busy_o           high while a job runs
//     done_o           one-cycle pulse after the last transfer
//   Build option:
//     EXP_WR_ROUND_EN  round half up before shifting (default: truncate)
module expand_output_writer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  out_ch_groups_i,
    input  logic [15:0] pixel_count_i,
    input  logic [2:0]  shift_i,
    input  logic [15:0] base_addr_i,
    expand_output_writer_if.master bus,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Job configuration
    logic [22:0] total_q;
    logic [2:0]  shift_q;
    logic [15:0] base_q;

    // Progress counters
    logic [22:0] issued_q;
    logic [22:0] xfer_q;
    logic        inflight_q;

    // Two-entry output buffer
    logic [63:0] buf_q [2];
    logic [1:0]  buf_cnt_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;

    logic        done_q;

    logic [22:0] start_total;
    logic        start_zero;
    logic        xfer;
    logic        last_xfer;
    logic [2:0]  occupancy;
    logic        credit_ok;
    logic        rd_en;
    logic        done_d;
    logic [63:0] q_word;

    // ReLU, shift, saturate one 12-bit signed lane.
    function automatic logic [7:0] quant_lane(input logic [11:0] s, input logic [2:0] sh);
        logic [11:0] r;
        logic [11:0] q;
        r = s[11] ? '0 : s;
`ifdef EXP_WR_ROUND_EN
        // r <= 0x7FF and the bias <= 0x40, so 12 bits cannot overflow.
        if (sh != 3'd0) begin
            r = r + (12'd1 << (sh - 3'd1));
        end
`endif
        q = r >> sh;
        return (q > 12'd255) ? 8'hFF : q[7:0];
    endfunction

    assign start_total = 23'(out_ch_groups_i) * 23'(pixel_count_i);
    assign start_zero  = (start_total == '0);

    assign bus.out_valid_o = (buf_cnt_q != 2'd0);
    assign bus.out_data_o  = buf_q[rd_ptr_q];
    assign bus.out_addr_o  = base_q + xfer_q[15:0];

    assign xfer      = bus.out_valid_o && bus.out_ready_i;
    assign last_xfer = xfer && (xfer_q == (total_q - 23'd1));

    // Words buffered plus the one possibly in flight must leave room for the
    // word a new read would bring back, counting the slot freed this cycle.
    assign occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    assign credit_ok = occupancy < (3'd2 + {2'b00, xfer});

    assign rd_en = (state_q == ST_RUN) &&
                   !bus.fifo_exp_3x3_empty_i &&
                   !bus.fifo_exp_1x1_empty_i &&
                   (issued_q < total_q) &&
                   credit_ok;

    assign bus.fifo_exp_3x3_rd_en_o = rd_en;
    assign bus.fifo_exp_1x1_rd_en_o = rd_en;

    assign busy_o = (state_q == ST_RUN);
    assign done_o = done_q;

    // Quantize the word returned by the FIFOs this cycle.
    always_comb begin
        q_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            q_word[63 - 8*i -: 8] = quant_lane(bus.fifo_exp_1x1_rd_data_i[47 - 12*i -: 12], shift_q);
            q_word[31 - 8*i -: 8] = quant_lane(bus.fifo_exp_3x3_rd_data_i[47 - 12*i -: 12], shift_q);
        end
    end

    // Next state; a start always wins, even over a finishing transfer.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (start_i) begin
            state_d = start_zero ? ST_IDLE : ST_RUN;
            done_d  = start_zero;
        end else if (state_q == ST_RUN && last_xfer) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            total_q    <= '0;
            shift_q    <= '0;
            base_q     <= '0;
            issued_q   <= '0;
            xfer_q     <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else if (start_i) begin
            // Abort/restart: a word popped in this cycle is dropped because
            // inflight_q is cleared and its data is never captured.
            total_q    <= start_total;
            shift_q    <= shift_i;
            base_q     <= base_addr_i;
            issued_q   <= '0;
            xfer_q     <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                issued_q <= issued_q + 23'd1;
            end
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= q_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
                xfer_q   <= xfer_q + 23'd1;
            end
            buf_cnt_q <= buf_cnt_q + 2'(inflight_q) - 2'(xfer);
        end
    end

endmodule
